// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the RV32I pipeline control block.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HOLD   = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        PC_HOLD = 2'd0,
        PC_INC  = 2'd1,
        PC_LOAD = 2'd2
    } pc_sel_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/pipe_pc_reg.sv
// Fetch PC register with hold / increment / load select.
module pipe_pc_reg
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  pc_sel_t     sel,
    input  logic [31:0] load_val,
    output logic [31:0] pc
);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else begin
            case (sel)
                PC_INC:  pc <= pc + PC_STEP;
                PC_LOAD: pc <= load_val;
                default: pc <= pc;
            endcase
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: fetch PC, IF/ID and ID/EX controls, halt/resume FSM, hazard watchdog.
// Optional perf counters enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MAX_WAIT = 3,
    parameter int          CNT_W    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        cannot_calcpc,
    input  logic        jump_taken,
    input  logic [31:0] jump_target,
    input  logic        halt_req,
    input  logic        resume,
    output logic [31:0] pcF,
    output logic        ifid_en,
    output logic        ifid_clr,
    output logic        idex_clr,
    output logic        halted,
    output logic        hazard_err
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] perf_hold_cycles,
    output logic [31:0] perf_flush_count
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    state_t           state_nxt;
    pc_sel_t          pc_sel;
    logic [CNT_W-1:0] hold_cnt;
    logic             hazard;
    logic             hazard_hold;

    assign hazard      = stall | cannot_calcpc;
    assign hazard_hold = (state != ST_HALTED) && hazard;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_HALTED: begin
                if (resume) state_nxt = ST_RUN;
            end
            default: begin
                if (hazard)        state_nxt = ST_HOLD;
                else if (halt_req) state_nxt = ST_HALTED;
                else               state_nxt = ST_RUN;
            end
        endcase
    end

    // HOLD with no hazard behaves exactly like RUN, so both share one branch.
    always_comb begin
        ifid_en  = 1'b1;
        ifid_clr = 1'b0;
        idex_clr = 1'b0;
        halted   = 1'b0;
        pc_sel   = PC_INC;
        if (reset) begin
            pc_sel = PC_HOLD;
        end else if (state == ST_HALTED) begin
            halted   = 1'b1;
            ifid_en  = 1'b0;
            idex_clr = 1'b1;
            pc_sel   = resume ? PC_INC : PC_HOLD;
        end else if (hazard) begin
            ifid_en  = 1'b0;
            idex_clr = 1'b1;
            pc_sel   = PC_HOLD;
        end else if (halt_req) begin
            ifid_clr = 1'b1;
            pc_sel   = PC_HOLD;
        end else if (jump_taken) begin
            ifid_clr = 1'b1;
            pc_sel   = PC_LOAD;
        end
    end

    pipe_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk      (clk),
        .reset    (reset),
        .sel      (pc_sel),
        .load_val (jump_target & ~32'h0000_0003),
        .pc       (pcF)
    );

    // Watchdog fires on the edge that completes the MAX_WAIT-th consecutive hold cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt   <= '0;
            hazard_err <= 1'b0;
        end else if (hazard_hold) begin
            if (hold_cnt != CNT_MAX) hold_cnt <= hold_cnt + 1'b1;
            if (int'(hold_cnt) + 1 >= MAX_WAIT) hazard_err <= 1'b1;
        end else begin
            hold_cnt <= '0;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_hold_cycles <= '0;
            perf_flush_count <= '0;
        end else if (state != ST_HALTED) begin
            if (idex_clr) perf_hold_cycles <= perf_hold_cycles + 32'd1;
            if (ifid_clr) perf_flush_count <= perf_flush_count + 32'd1;
        end
    end
`endif

endmodule
